// File: rtl/shift_unit_seq.sv
// Sequential barrel-free shifter: one bit per clock for LSR / ASR / LSL / ROR,
// with a valid/ready request port and a valid/ready result port.
module shift_unit_seq #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               carry,
   output logic               zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       MODE_LSR = 2'b00;
   localparam logic [1:0]       MODE_ASR = 2'b01;
   localparam logic [1:0]       MODE_LSL = 2'b10;
   localparam logic [1:0]       MODE_ROR = 2'b11;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [1:0]         mode_q, mode_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               carry_q, carry_d;
   logic               zero_q, zero_d;

   logic [31:0]        shamt_ext_s;
   logic [31:0]        n_s;
   logic [WIDTH-1:0]   step_s;
   logic               step_carry_s;

   // Effective step count: saturate at WIDTH for shifts, wrap for rotates.
   always_comb begin
      shamt_ext_s = 32'(shamt);
      if (mode == MODE_ROR) begin
         n_s = shamt_ext_s % 32'(WIDTH);
      end else if (shamt_ext_s >= 32'(WIDTH)) begin
         n_s = 32'(WIDTH);
      end else begin
         n_s = shamt_ext_s;
      end
   end

   // One-bit step of the working register and the bit that leaves it.
   always_comb begin
      step_s       = work_q;
      step_carry_s = 1'b0;
      case (mode_q)
         MODE_LSR: begin
            step_s       = {1'b0, work_q[WIDTH-1:1]};
            step_carry_s = work_q[0];
         end
         MODE_ASR: begin
            step_s       = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            step_carry_s = work_q[0];
         end
         MODE_LSL: begin
            step_s       = {work_q[WIDTH-2:0], 1'b0};
            step_carry_s = work_q[WIDTH-1];
         end
         MODE_ROR: begin
            step_s       = {work_q[0], work_q[WIDTH-1:1]};
            step_carry_s = work_q[0];
         end
         default: begin
            step_s       = work_q;
            step_carry_s = 1'b0;
         end
      endcase
   end

   // Next-state and datapath update for the IDLE / SHIFT / DONE sequence.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      mode_d  = mode_q;
      count_d = count_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = a;
               mode_d  = mode;
               count_d = n_s[CNT_W-1:0];
               carry_d = 1'b0;
               if (n_s != 32'd0) begin
                  state_d = SHIFT;
               end else begin
                  state_d = DONE;
                  zero_d  = (a == {WIDTH{1'b0}});
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            work_d  = step_s;
            carry_d = step_carry_s;
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
               state_d = DONE;
               zero_d  = (step_s == {WIDTH{1'b0}});
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= {WIDTH{1'b0}};
         mode_q  <= 2'b00;
         count_q <= {CNT_W{1'b0}};
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign result    = work_q;
   assign carry     = carry_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq (WIDTH=8, SHAMT_W=4).
module tb_shift_unit_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [3:0] shamt;
   logic [1:0] mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       carry;
   logic       zero;

   int n_checks = 0;
   int n_fail   = 0;

   shift_unit_seq #(.WIDTH(8), .SHAMT_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .shamt(shamt), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request, accept it, then scramble the inputs.
   task automatic start_op(input string tag, input logic [7:0] av, input logic [3:0] sv, input logic [1:0] mv);
      in_valid = 1'b1;
      a        = av;
      shamt    = sv;
      mode     = mv;
      check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = ~av;
      shamt    = ~sv;
      mode     = ~mv;
   endtask

   task automatic wait_result(input string tag, input int exp_lat, input logic [7:0] er,
                              input logic ec, input logic ez);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_val({tag, "_result"},  32'(result), 32'(er));
      check_val({tag, "_carry"},   32'(carry),  32'(ec));
      check_val({tag, "_zero"},    32'(zero),   32'(ez));
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
      check_val({tag, "_in_ready_back"},  32'(in_ready),  32'd1);
   endtask

   task automatic run_op(input string tag, input logic [7:0] av, input logic [3:0] sv, input logic [1:0] mv,
                         input int exp_lat, input logic [7:0] er, input logic ec, input logic ez);
      start_op(tag, av, sv, mv);
      wait_result(tag, exp_lat, er, ec, ez);
      consume(tag);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 8'h00;
      shamt     = 4'h0;
      mode      = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_ready",  32'(in_ready),  32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_result",    32'(result),    32'd0);
      check_val("rst_carry",     32'(carry),     32'd0);
      check_val("rst_zero",      32'(zero),      32'd0);
      rst = 1'b0;
      #1;
      check_val("idle_in_ready", 32'(in_ready), 32'd1);

      run_op("lsr_b4_3",   8'hB4, 4'd3,  2'b00, 3, 8'h16, 1'b1, 1'b0);
      run_op("asr_90_12",  8'h90, 4'd12, 2'b01, 8, 8'hFF, 1'b1, 1'b0);
      run_op("lsl_81_1",   8'h81, 4'd1,  2'b10, 1, 8'h02, 1'b1, 1'b0);
      run_op("ror_81_9",   8'h81, 4'd9,  2'b11, 1, 8'hC0, 1'b1, 1'b0);
      run_op("lsr_01_1",   8'h01, 4'd1,  2'b00, 1, 8'h00, 1'b1, 1'b1);
      for (int m = 0; m < 4; m++) begin
         run_op($sformatf("zero_amt_m%0d", m), 8'h5A, 4'd0, 2'(m), 0, 8'h5A, 1'b0, 1'b0);
      end
      run_op("lsl_81_15",  8'h81, 4'd15, 2'b10, 8, 8'h00, 1'b1, 1'b1);
      run_op("lsr_7f_8",   8'h7F, 4'd8,  2'b00, 8, 8'h00, 1'b0, 1'b1);
      run_op("asr_70_9",   8'h70, 4'd9,  2'b01, 8, 8'h00, 1'b0, 1'b1);
      run_op("ror_5a_8",   8'h5A, 4'd8,  2'b11, 0, 8'h5A, 1'b0, 1'b0);
      run_op("ror_96_3",   8'h96, 4'd3,  2'b11, 3, 8'hD2, 1'b1, 1'b0);

      // Back-pressure in DONE with stray requests on the input side.
      start_op("stall", 8'h81, 4'd1, 2'b10);
      wait_result("stall", 1, 8'h02, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         a        = 8'h3C;
         shamt    = 4'd2;
         mode     = 2'b00;
         check_val($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         check_val($sformatf("stall_valid_%0d", i),  32'(out_valid), 32'd1);
         check_val($sformatf("stall_result_%0d", i), 32'(result),    32'h02);
         check_val($sformatf("stall_carry_%0d", i),  32'(carry),     32'd1);
         check_val($sformatf("stall_zero_%0d", i),   32'(zero),      32'd0);
      end
      in_valid = 1'b0;
      consume("stall");
      @(posedge clk); #1;
      check_val("stall_no_extra_accept", 32'(in_ready), 32'd1);

      // Abort an 8-step ASR two cycles in, then run a clean request.
      start_op("abort", 8'h90, 4'd12, 2'b01);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_val("abort_out_valid", 32'(out_valid), 32'd0);
      check_val("abort_result",    32'(result),    32'd0);
      check_val("abort_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      run_op("after_rst_lsr_f0_4", 8'hF0, 4'd4, 2'b00, 4, 8'h0F, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL be >= 2.
REQ-002 Parameter SHAMT_W, default 4, shift-amount width in bits; SHALL be >= 1.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  request present on a, shamt, mode.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 a  in  WIDTH  operand.
REQ-008 shamt  in  SHAMT_W  requested shift amount, unsigned.
REQ-009 mode  in  2  00 LSR (logical right), 01 ASR (arithmetic right), 10 LSL (logical left), 11 ROR (rotate right).
REQ-010 out_valid  out  1  result, carry, zero valid.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 result  out  WIDTH  shifted operand, registered.
REQ-013 carry  out  1  last bit shifted or rotated out; 0 when no shift occurs.
REQ-014 zero  out  1  result == 0, registered with result.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low; out_valid SHALL be 1 only in DONE.
REQ-017 Accept on the edge where in_valid && in_ready: latch a into the working register, latch mode, load count = n, clear carry.
REQ-018 Effective amount n: LSR/LSL/ASR n = min(shamt, WIDTH); ROR n = shamt mod WIDTH.
REQ-019 On accept, next state SHALL be SHIFT if n > 0, else DONE.
REQ-020 In SHIFT, each edge SHALL perform exactly one 1-bit step per mode: LSR inserts 0 at MSB; ASR replicates MSB; LSL inserts 0 at LSB; ROR moves LSB to MSB.
REQ-021 Each SHIFT step SHALL set carry to the bit leaving the word (LSB for LSR/ASR/ROR, MSB for LSL) and decrement count.
REQ-022 When count == 1 at a SHIFT edge, that step SHALL complete and the next state SHALL be DONE.
REQ-023 Latency: out_valid SHALL rise in the cycle after the edge accept + n (n = 0 gives the cycle directly after accept).
REQ-024 zero SHALL equal the NOR of the final result and be valid whenever out_valid is 1.
REQ-025 In DONE, result, carry and zero SHALL hold stable until out_valid && out_ready; that edge returns the FSM to IDLE.
REQ-026 The block SHALL accept no new request before return to IDLE; in_valid in SHIFT/DONE SHALL be ignored, with no queuing.
REQ-027 Inputs a, shamt and mode SHALL be sampled only at accept; later changes SHALL not affect the operation.
REQ-028 Shift amounts >= WIDTH (non-ROR) SHALL give full fill: all 0 for LSR/LSL, all sign bit for ASR; carry = a[WIDTH-1] for LSR/ASR and a[0] for LSL.

Reset
REQ-029 While rst is high: state IDLE, result 0, carry 0, zero 0, out_valid 0, count 0, in_ready 0.
REQ-030 rst asserted mid-operation SHALL abort immediately with no partial result presented; the first request after release SHALL complete correctly.

Verification (WIDTH=8, SHAMT_W=4)
REQ-031 LSR a=0xB4 shamt=3 -> result 0x16, carry 1, zero 0; out_valid 3 cycles after accept.
REQ-032 ASR a=0x90 shamt=12 -> n=8, result 0xFF, carry 1; out_valid 8 cycles after accept.
REQ-033 LSL a=0x81 shamt=1 -> 0x02, carry 1; ROR a=0x81 shamt=9 -> n=1, 0xC0, carry 1; LSR a=0x01 shamt=1 -> 0x00, zero 1.
REQ-034 Any mode a=0x5A shamt=0 -> result 0x5A, carry 0, zero 0; out_valid in the cycle after accept.
REQ-035 out_ready held low 5 cycles in DONE while in_valid pulses -> outputs stable, in_ready 0, no extra accept; then out_ready=1 -> IDLE, in_ready 1 next cycle.
REQ-036 rst pulsed 2 cycles into an 8-step ASR -> out_valid 0 and result 0 at once; a new LSR a=0xF0 shamt=4 after release -> 0x0F, carry 0.
